// File: rtl/leaf_out_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// leaf_out_arbiter_pkg
// Shared constants for the leaf output path:
//   - default geometry of the BFT packet and of the arbiter
//   - packet field offsets for the default geometry, used by blocks that
//     decode packets leaving the leaf
//   - ptr_width(): width of an index into n ports (never zero)
// No ports (package).
// -----------------------------------------------------------------------------
package leaf_out_arbiter_pkg;

    localparam int PACKET_BITS_DEF           = 49;
    localparam int PAYLOAD_BITS_DEF          = 32;
    localparam int NUM_LEAF_BITS_DEF         = 5;
    localparam int NUM_PORT_BITS_DEF         = 4;
    localparam int NUM_ADDR_BITS_DEF         = 7;
    localparam int NUM_OUT_PORTS_DEF         = 4;
    localparam int NUM_BRAM_ADDR_BITS_DEF    = 7;
    localparam int FREESPACE_UPDATE_SIZE_DEF = 64;

    // Packet layout: [VLD_BIT] valid, then dst_leaf, dst_port, seq, payload.
    localparam int ADDR_LSB = PAYLOAD_BITS_DEF;
    localparam int PORT_LSB = ADDR_LSB + NUM_ADDR_BITS_DEF;
    localparam int LEAF_LSB = PORT_LSB + NUM_PORT_BITS_DEF;
    localparam int VLD_BIT  = LEAF_LSB + NUM_LEAF_BITS_DEF;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// -----------------------------------------------------------------------------
// leaf_out_arbiter_if
// Bundles the user-side output streams, the configuration and credit return
// paths, and the packet output toward the BFT.
//   master : the user kernel / controller side (drives streams, cfg, credit)
//   slave  : the arbiter (drives ack_user and dout_pkt)
// -----------------------------------------------------------------------------
interface leaf_out_arbiter_if #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_OUT_PORTS = 4
);
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_user;
    logic [NUM_OUT_PORTS-1:0]              vld_user;
    logic [NUM_OUT_PORTS-1:0]              ack_user;
    logic                                  cfg_we;
    logic [NUM_PORT_BITS-1:0]              cfg_port;
    logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf;
    logic [NUM_PORT_BITS-1:0]              cfg_dst_port;
    logic                                  credit_vld;
    logic [NUM_PORT_BITS-1:0]              credit_port;
    logic                                  resend;
    logic [PACKET_BITS-1:0]                dout_pkt;

    modport master (
        output din_user, vld_user, cfg_we, cfg_port, cfg_dst_leaf, cfg_dst_port,
               credit_vld, credit_port, resend,
        input  ack_user, dout_pkt
    );

    modport slave (
        input  din_user, vld_user, cfg_we, cfg_port, cfg_dst_leaf, cfg_dst_port,
               credit_vld, credit_port, resend,
        output ack_user, dout_pkt
    );
endinterface

// File: rtl/leaf_out_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_onehot
// Round-robin one-hot arbiter. The search starts one past the last winner;
// the pointer resets to N-1 so that port 0 has first priority.
//   clk, reset : clock, asynchronous active-high reset
//   req[N]     : requesting ports
//   adv        : a grant was taken this cycle; move the pointer to the winner
//   gnt[N]     : combinational one-hot grant (all zero when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter_onehot
    import leaf_out_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         adv,
    output logic [N-1:0] gnt
);
    localparam int PW = ptr_width(N);

    logic [PW-1:0] rr_ptr_reg;
    logic [PW-1:0] rr_ptr_next;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        gnt         = '0;
        rr_ptr_next = rr_ptr_reg;
        found       = 1'b0;
        idx         = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(rr_ptr_reg) + k) % N);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt[idx]    = 1'b1;
                rr_ptr_next = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= PW'(N - 1);
        end else if (adv) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
endmodule

// File: rtl/leaf_out_arbiter.sv
// -----------------------------------------------------------------------------
// leaf_out_arbiter
// Shares the single leaf-to-BFT packet link among the user output streams.
// One stream is granted per cycle, round-robin, among streams that are valid,
// configured and hold downstream credit. The granted payload is packed with
// the configured destination and a per-port sequence number and registered
// onto dout_pkt (all zero when idle).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : leaf_out_arbiter_if.slave (streams, cfg, credit, resend,
//                ack_user, dout_pkt)
// -----------------------------------------------------------------------------
module leaf_out_arbiter
    import leaf_out_arbiter_pkg::*;
#(
    parameter int PACKET_BITS           = PACKET_BITS_DEF,
    parameter int PAYLOAD_BITS          = PAYLOAD_BITS_DEF,
    parameter int NUM_LEAF_BITS         = NUM_LEAF_BITS_DEF,
    parameter int NUM_PORT_BITS         = NUM_PORT_BITS_DEF,
    parameter int NUM_ADDR_BITS         = NUM_ADDR_BITS_DEF,
    parameter int NUM_OUT_PORTS         = NUM_OUT_PORTS_DEF,
    parameter int NUM_BRAM_ADDR_BITS    = NUM_BRAM_ADDR_BITS_DEF,
    parameter int FREESPACE_UPDATE_SIZE = FREESPACE_UPDATE_SIZE_DEF
) (
    input  logic               clk,
    input  logic               reset,
    leaf_out_arbiter_if.slave  bus
);
    localparam int CW = NUM_BRAM_ADDR_BITS + 1;
    localparam logic [CW-1:0] CREDIT_MAX = CW'(2 ** NUM_BRAM_ADDR_BITS);
    localparam logic [CW:0]   CREDIT_UPD = (CW + 1)'(FREESPACE_UPDATE_SIZE);

    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] gnt;
    logic [PACKET_BITS-1:0]   pkt_vec [NUM_OUT_PORTS];
    logic [PACKET_BITS-1:0]   pkt_next;
    logic [PACKET_BITS-1:0]   dout_pkt_reg;

    generate
        for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
            logic                     cfg_ok_reg;
            logic [NUM_LEAF_BITS-1:0] dst_leaf_reg;
            logic [NUM_PORT_BITS-1:0] dst_port_reg;
            logic [CW-1:0]            credit_reg;
            logic [CW-1:0]            credit_next;
            logic [CW:0]              credit_sum;
            logic [NUM_ADDR_BITS-1:0] seq_reg;
            logic                     cfg_hit;
            logic                     upd_hit;

            // Out-of-range cfg/credit ports never match any generated port.
            assign cfg_hit = bus.cfg_we     && (bus.cfg_port    == NUM_PORT_BITS'(gi));
            assign upd_hit = bus.credit_vld && (bus.credit_port == NUM_PORT_BITS'(gi));

            assign eligible[gi] = bus.vld_user[gi] & cfg_ok_reg &
                                  (credit_reg != '0) & ~bus.resend;

            // Grant and update combine first (net +SIZE-1), then saturate.
            // A grant needs nonzero credit, so the subtraction cannot wrap.
            always_comb begin
                credit_sum  = {1'b0, credit_reg} + (upd_hit ? CREDIT_UPD : '0)
                              - {{CW{1'b0}}, gnt[gi]};
                credit_next = (credit_sum > {1'b0, CREDIT_MAX}) ? CREDIT_MAX
                                                                : credit_sum[CW-1:0];
            end

            // The packet uses the table entry as it stands before this edge,
            // so a same-cycle cfg write affects only the following packet.
            assign pkt_vec[gi] = gnt[gi] ?
                {1'b1, dst_leaf_reg, dst_port_reg, seq_reg,
                 bus.din_user[gi*PAYLOAD_BITS +: PAYLOAD_BITS]} : '0;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cfg_ok_reg   <= 1'b0;
                    dst_leaf_reg <= '0;
                    dst_port_reg <= '0;
                    credit_reg   <= CREDIT_MAX;
                    seq_reg      <= '0;
                end else begin
                    if (cfg_hit) begin
                        cfg_ok_reg   <= 1'b1;
                        dst_leaf_reg <= bus.cfg_dst_leaf;
                        dst_port_reg <= bus.cfg_dst_port;
                    end
                    credit_reg <= credit_next;
                    if (gnt[gi]) begin
                        seq_reg <= seq_reg + NUM_ADDR_BITS'(1);
                    end
                end
            end
        end
    endgenerate

    rr_arbiter_onehot #(.N(NUM_OUT_PORTS)) u_rr (
        .clk   (clk),
        .reset (reset),
        .req   (eligible),
        .adv   (|gnt),
        .gnt   (gnt)
    );

    // Grant is one-hot, so OR-ing the per-port candidates is the mux.
    always_comb begin
        pkt_next = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            pkt_next = pkt_next | pkt_vec[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_pkt_reg <= '0;
        end else begin
            dout_pkt_reg <= pkt_next;
        end
    end

    assign bus.ack_user = gnt;
    assign bus.dout_pkt = dout_pkt_reg;
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// -----------------------------------------------------------------------------
// tb_leaf_out_arbiter
// Directed stimulus for leaf_out_arbiter. A behavioural model (credit/seq
// arrays, destination table, last-winner index) predicts ack_user and
// dout_pkt every cycle; literal expectations pin specific packets and counts.
// -----------------------------------------------------------------------------
module tb_leaf_out_arbiter;
    import leaf_out_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    leaf_out_arbiter_if #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
        .NUM_PORT_BITS(4), .NUM_OUT_PORTS(N)
    ) bus ();

    leaf_out_arbiter #(
        .PACKET_BITS(49), .PAYLOAD_BITS(32), .NUM_LEAF_BITS(5),
        .NUM_PORT_BITS(4), .NUM_ADDR_BITS(7), .NUM_OUT_PORTS(N),
        .NUM_BRAM_ADDR_BITS(7), .FREESPACE_UPDATE_SIZE(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ack_cnt [N];
    int grant_q [$];

    // Model state
    int          m_credit [N];
    int          m_seq    [N];
    bit          m_ok     [N];
    int          m_leaf   [N];
    int          m_port   [N];
    int          m_last;
    logic [48:0] exp_pkt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_credit[i] = 128;
            m_seq[i]    = 0;
            m_ok[i]     = 1'b0;
            m_leaf[i]   = 0;
            m_port[i]   = 0;
        end
        m_last  = N - 1;
        exp_pkt = '0;
    endtask

    // Compare process: mid-cycle, inputs stable.
    always @(negedge clk) begin
        int win;
        int p;
        if (reset) begin
            model_reset();
            check("reset_ack", 64'(bus.ack_user), 64'd0);
            check("reset_dout", 64'(bus.dout_pkt), 64'd0);
        end else begin
            check("dout", 64'(bus.dout_pkt), 64'(exp_pkt));
            win = -1;
            for (int k = 1; k <= N; k++) begin
                p = (m_last + k) % N;
                if (win < 0 && bus.vld_user[p] && m_ok[p] && m_credit[p] > 0 && !bus.resend)
                    win = p;
            end
            check("ack", 64'(bus.ack_user), (win < 0) ? 64'd0 : (64'd1 << win));
            for (int i = 0; i < N; i++) begin
                if (bus.ack_user[i]) begin
                    ack_cnt[i]++;
                    grant_q.push_back(i);
                end
            end
            if (win >= 0) begin
                exp_pkt = (49'd1 << VLD_BIT) | (49'(m_leaf[win]) << LEAF_LSB) |
                          (49'(m_port[win]) << PORT_LSB) | (49'(m_seq[win]) << ADDR_LSB) |
                          49'(bus.din_user[win*32 +: 32]);
                m_credit[win] = m_credit[win] - 1;
                m_seq[win]    = (m_seq[win] + 1) % 128;
                m_last        = win;
            end else begin
                exp_pkt = '0;
            end
            if (bus.credit_vld && bus.credit_port < N) begin
                m_credit[bus.credit_port] = m_credit[bus.credit_port] + 64;
                if (m_credit[bus.credit_port] > 128) m_credit[bus.credit_port] = 128;
            end
            if (bus.cfg_we && bus.cfg_port < N) begin
                m_ok[bus.cfg_port]   = 1'b1;
                m_leaf[bus.cfg_port] = int'(bus.cfg_dst_leaf);
                m_port[bus.cfg_port] = int'(bus.cfg_dst_port);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic cfg(input int port, input int leaf, input int dport);
        bus.cfg_we       = 1'b1;
        bus.cfg_port     = 4'(port);
        bus.cfg_dst_leaf = 5'(leaf);
        bus.cfg_dst_port = 4'(dport);
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic credit(input int port);
        bus.credit_vld  = 1'b1;
        bus.credit_port = 4'(port);
        tick(1);
        bus.credit_vld = 1'b0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        grant_q.delete();
    endtask

    initial begin
        int exp_a [8];
        int exp_b [6];
        exp_a = '{0, 1, 2, 3, 0, 1, 2, 3};
        exp_b = '{0, 2, 3, 0, 2, 3};

        reset            = 1'b1;
        bus.din_user     = '0;
        bus.vld_user     = '0;
        bus.cfg_we       = 1'b0;
        bus.cfg_port     = '0;
        bus.cfg_dst_leaf = '0;
        bus.cfg_dst_port = '0;
        bus.credit_vld   = 1'b0;
        bus.credit_port  = '0;
        bus.resend       = 1'b0;
        clear_counts();
        tick(2);
        check("init_ack", 64'(bus.ack_user), 64'd0);
        check("init_dout", 64'(bus.dout_pkt), 64'd0);
        reset = 1'b0;

        // Single stream: packet format, seq progression, credit exhaustion.
        cfg(0, 3, 2);
        bus.din_user[31:0] = 32'hDEADBEEF;
        bus.vld_user       = 4'b0001;
        clear_counts();
        tick(1);
        check("pkt_seq0", 64'(bus.dout_pkt), 64'(49'h1_1900_DEADBEEF));
        tick(4);
        check("pkt_seq4", 64'(bus.dout_pkt), 64'(49'h1_1904_DEADBEEF));
        tick(123);
        check("pkt_seq127", 64'(bus.dout_pkt), 64'(49'h1_197F_DEADBEEF));
        check("acks_128", 64'(ack_cnt[0]), 64'd128);
        check("no_credit_ack", 64'(bus.ack_user), 64'd0);
        credit(0);
        clear_counts();
        tick(1);
        check("pkt_seq_wrap", 64'(bus.dout_pkt), 64'(49'h1_1900_DEADBEEF));
        tick(9);
        credit(0);          // grant and update together: 54 -> 117
        tick(130);
        check("acks_after_refill", 64'(ack_cnt[0]), 64'd128);
        bus.vld_user = '0;

        // Credit saturation at full credit; out-of-range credit port ignored.
        do_reset();
        cfg(0, 3, 2);
        credit(0);
        credit(0);
        credit(0);
        credit(5);
        bus.vld_user = 4'b0001;
        clear_counts();
        tick(140);
        check("acks_saturated", 64'(ack_cnt[0]), 64'd128);
        bus.vld_user = '0;

        // Four streams: round-robin order, drop one stream, resend pause.
        do_reset();
        for (int i = 0; i < N; i++) cfg(i, i + 1, i);
        cfg(9, 31, 15);
        for (int i = 0; i < N; i++) bus.din_user[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        bus.vld_user = 4'b1111;
        clear_counts();
        tick(8);
        check("rr_count", 64'(grant_q.size()), 64'd8);
        for (int k = 0; k < 8; k++) check($sformatf("rr_order%0d", k), 64'(grant_q[k]), 64'(exp_a[k]));
        bus.vld_user = 4'b1101;
        clear_counts();
        tick(6);
        check("rr_drop_count", 64'(grant_q.size()), 64'd6);
        for (int k = 0; k < 6; k++) check($sformatf("rr_drop%0d", k), 64'(grant_q[k]), 64'(exp_b[k]));
        bus.resend = 1'b1;
        clear_counts();
        tick(5);
        check("resend_acks", 64'(grant_q.size()), 64'd0);
        check("resend_dout", 64'(bus.dout_pkt), 64'd0);
        bus.resend = 1'b0;
        clear_counts();
        tick(1);
        check("resume_count", 64'(grant_q.size()), 64'd1);
        check("resume_port", 64'(grant_q[0]), 64'd0);
        check("resume_pkt", 64'(bus.dout_pkt), 64'(49'h1_0804_A0000000));
        bus.vld_user = '0;

        // Unconfigured ports never granted; asynchronous reset mid-stream.
        do_reset();
        cfg(1, 7, 3);
        bus.vld_user = 4'b1111;
        clear_counts();
        tick(20);
        check("unconf_p0", 64'(ack_cnt[0]), 64'd0);
        check("conf_p1", 64'(ack_cnt[1]), 64'd20);
        check("unconf_p2", 64'(ack_cnt[2]), 64'd0);
        check("unconf_p3", 64'(ack_cnt[3]), 64'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_rst_dout", 64'(bus.dout_pkt), 64'd0);
        check("async_rst_ack", 64'(bus.ack_user), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cfg(1, 7, 3);
        clear_counts();
        tick(140);
        check("credit_after_rst", 64'(ack_cnt[1]), 64'd128);
        check("p0_after_rst", 64'(ack_cnt[0]), 64'd0);
        bus.vld_user = '0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Shares the single 49-bit leaf-to-BFT output link among the user kernel's output streams. Sits between the user-side output handshake (`din_leaf_user2interface_*` / `vld_user2interface_*` / `ack_interface2user_*`) and `dout_leaf_interface2bft`. It grants one stream per cycle in round-robin order and tracks per-port downstream credit. It packs each payload with a configured destination leaf/port and a per-port sequence address.

## Interface
Parameters:
- PACKET_BITS, 49, packet width on the BFT link
- PAYLOAD_BITS, 32, user payload width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, sequence/address field width
- NUM_OUT_PORTS, 4, number of user output streams (≤ 2^NUM_PORT_BITS)
- NUM_BRAM_ADDR_BITS, 7, receiver buffer depth log2; initial credit = 2^NUM_BRAM_ADDR_BITS
- FREESPACE_UPDATE_SIZE, 64, credits returned per update

Ports:
- clk, in, 1, sole clock
- reset, in, 1, asynchronous active-high reset
- din_user, in, NUM_OUT_PORTS*PAYLOAD_BITS, stream i payload at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
- vld_user, in, NUM_OUT_PORTS, stream i holds valid data
- ack_user, out, NUM_OUT_PORTS, one-hot grant; payload is consumed on that clock edge
- cfg_we, in, 1, write destination-table entry
- cfg_port, in, NUM_PORT_BITS, local output port being configured
- cfg_dst_leaf, in, NUM_LEAF_BITS, destination leaf for cfg_port
- cfg_dst_port, in, NUM_PORT_BITS, destination port for cfg_port
- credit_vld, in, 1, freespace update strobe
- credit_port, in, NUM_PORT_BITS, local port receiving FREESPACE_UPDATE_SIZE credits
- resend, in, 1, pause: no grants while high
- dout_pkt, out, PACKET_BITS, registered packet to BFT; all-zero when idle

## Operation
- Packet format: [48] valid=1, [47:43] dst_leaf, [42:39] dst_port, [38:32] seq, [31:0] payload.
- Per port state:
  - cfg_ok flag, reset 0, set by cfg_we.
  - dst table entry, reset 0.
  - credit counter of width NUM_BRAM_ADDR_BITS+1, reset 2^NUM_BRAM_ADDR_BITS.
  - seq counter, reset 0.
- Eligible(i) = vld_user[i] & cfg_ok[i] & credit[i]≠0 & !resend.
- Round-robin selection:
  - Search starts at rr_ptr+1 mod NUM_OUT_PORTS. The first eligible port wins.
  - On a grant, rr_ptr ← winner. rr_ptr resets to NUM_OUT_PORTS-1, so port 0 has first priority.
- ack_user is combinational: it equals the one-hot winner. The user drops or advances its data after seeing ack, and never sees a double grant.
- On a grant to port i, at the clock edge:
  - dout_pkt is loaded with the packet.
  - credit[i] is decremented by 1.
  - seq[i] is incremented modulo 2^NUM_ADDR_BITS; 127 wraps to 0.
- No grant: dout_pkt ← 0.
- credit_vld adds FREESPACE_UPDATE_SIZE to credit[credit_port].
  - The result saturates at 2^NUM_BRAM_ADDR_BITS.
  - A grant and an update to the same port in the same cycle net +SIZE−1, then saturate.
  - A credit_port ≥ NUM_OUT_PORTS is ignored.
- A cfg_we to a port that is granted in the same cycle takes effect from the next packet. The current packet uses the old entry.
- A cfg_port ≥ NUM_OUT_PORTS is ignored.
- resend high: ack_user=0 and dout_pkt ← 0 on the next edge. Credit, seq and rr_ptr are held.
- reset mid-operation: all state returns to reset values immediately (asynchronous). An in-flight dout_pkt is cleared.

## Timing
- Grant-to-output latency: 1 cycle. A packet appears on dout_pkt in the cycle after ack_user is high.
- Throughput: 1 packet/cycle aggregate.
- A single continuously-valid stream with credit gets a packet every cycle.
- With N eligible streams, each stream is granted once every N cycles.
- Reset values: ack_user=0, dout_pkt=0.
- ack_user depends combinationally on vld_user, resend and registered state only. There is no path from dout_pkt.

## Structure
- Shared package (leaf_pkg): packet field offsets (VLD_BIT, LEAF_LSB, PORT_LSB, ADDR_LSB) and the default parameter constants. Used by leaf_interface for decode.
- One sub-module, rr_arbiter_onehot:
  - Parameter N.
  - Ports: clk, reset, req[N], adv, gnt[N].
  - Holds rr_ptr.
- The credit, seq and cfg arrays stay in the top level.
- Target size: ~200 lines of RTL.

## Test plan
- Reset, then cfg port0→(leaf 3, port 2), hold vld_user[0] with payload 0xDEADBEEF → ack_user=0001 every cycle.
  - dout_pkt = {1, 5'd3, 4'd2, seq, 0xDEADBEEF}.
  - seq runs 0,1,2,…, wrapping from 127 to 0.
- Configure all 4 ports, assert all vld → grant order 0,1,2,3,0,… and each stream gets 25% of cycles. Drop vld[1] → order 0,2,3,0.
- Port 0 streams with no credit_vld → exactly 128 acks, then ack stops.
  - A credit_vld for port 0 restores 64 more packets.
  - A simultaneous grant and update leaves credit = old+63.
- Issue 3 credit_vld to port 0 while it is idle at full credit → credit stays at 128 (saturation).
- Assert resend for 5 cycles mid-stream → ack_user=0 and dout_pkt=0 during resend. The stream resumes with the next seq and the rr order is preserved.
- Unconfigured port with vld held → never acked. Assert reset asynchronously mid-stream → dout_pkt=0 immediately and credits return to 128.
